// File: rtl/vtiming_pkg.sv
// Shared types and mode defaults for the video timing generator.
// Region enums, the delayed sync bundle, and 640x480/800x600 modes.
package vtiming_pkg;

  typedef enum logic [1:0] {
    H_ACT,
    H_FP,
    H_SY,
    H_BP
  } h_state_t;

  typedef enum logic [1:0] {
    V_ACT,
    V_FP,
    V_SY,
    V_BP
  } v_state_t;

  // Generic region order shared by both axes.
  typedef enum logic [1:0] {
    AX_ACT,
    AX_FRONT,
    AX_SYNC,
    AX_BACK
  } axis_state_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
    logic line;
    logic frame;
  } sync_bits_t;

  localparam sync_bits_t SYNC_FLUSHED = '{
    hsync: 1'b0,
    vsync: 1'b0,
    blank: 1'b1,
    line:  1'b0,
    frame: 1'b0
  };

  // 640x480 @ 60 Hz
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FRONT  = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BACK   = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FRONT  = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BACK   = 33;

  // 800x600 @ 72 Hz
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FRONT  = 56;
  localparam int SVGA800_H_SYNC   = 120;
  localparam int SVGA800_H_BACK   = 64;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FRONT  = 37;
  localparam int SVGA800_V_SYNC   = 6;
  localparam int SVGA800_V_BACK   = 23;

  // True when an unsigned field of the given width holds value.
  function automatic bit fits(
    input int value,
    input int bits
  );
    return (bits >= 31) || (value < (1 << bits));
  endfunction

endpackage

// File: rtl/vtiming_axis.sv
// One timing axis: four-region FSM with per-region down-counter
// plus a free position counter. Ports: clk/rst/adv in; region/pos/wrap out.
module vtiming_axis
  import vtiming_pkg::*;
#(
  parameter int W       = 10,
  parameter int L_ACT   = 640,
  parameter int L_FRONT = 16,
  parameter int L_SYNC  = 96,
  parameter int L_BACK  = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output axis_state_t region,
  output logic [W-1:0] pos,
  output logic        wrap
);

  localparam int TOTAL = L_ACT + L_FRONT + L_SYNC + L_BACK;

  localparam logic [W-1:0] LAST_ACT   = W'(L_ACT - 1);
  localparam logic [W-1:0] LAST_FRONT = W'(L_FRONT - 1);
  localparam logic [W-1:0] LAST_SYNC  = W'(L_SYNC - 1);
  localparam logic [W-1:0] LAST_BACK  = W'(L_BACK - 1);
  localparam logic [W-1:0] LAST_POS   = W'(TOTAL - 1);

  axis_state_t  state;
  axis_state_t  nextState;
  logic [W-1:0] regionCnt;
  logic [W-1:0] nextCnt;
  logic [W-1:0] nextPos;
  logic         regionEnd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= AX_ACT;
      regionCnt <= LAST_ACT;
      pos       <= '0;
    end else if (adv) begin
      state     <= nextState;
      regionCnt <= nextCnt;
      pos       <= nextPos;
    end
  end

  always_comb begin
    regionEnd = (regionCnt == '0);
    nextState = state;
    nextCnt   = regionCnt - 1'b1;
    nextPos   = (pos == LAST_POS) ? '0 : pos + 1'b1;
    if (regionEnd) begin
      unique case (state)
        AX_ACT: begin
          nextState = AX_FRONT;
          nextCnt   = LAST_FRONT;
        end
        AX_FRONT: begin
          nextState = AX_SYNC;
          nextCnt   = LAST_SYNC;
        end
        AX_SYNC: begin
          nextState = AX_BACK;
          nextCnt   = LAST_BACK;
        end
        default: begin
          nextState = AX_ACT;
          nextCnt   = LAST_ACT;
        end
      endcase
    end
  end

  // Last position of the axis: back porch on its final count.
  always_comb begin
    region = state;
    wrap   = (state == AX_BACK) && regionEnd;
  end

endmodule

// File: rtl/vtiming_gen.sv
// Parametrised video timing generator with delayed sync/blank/strobes.
// In: PixelClkSrc, PixelRst, PixelEn. Out: PixelX/Y, FetchActive, syncs, strobes.
module vtiming_gen
  import vtiming_pkg::*;
#(
  parameter int XBITS     = 10,
  parameter int YBITS     = 10,
  parameter int H_ACTIVE  = VGA640_H_ACTIVE,
  parameter int H_FRONT   = VGA640_H_FRONT,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BACK    = VGA640_H_BACK,
  parameter int V_ACTIVE  = VGA640_V_ACTIVE,
  parameter int V_FRONT   = VGA640_V_FRONT,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BACK    = VGA640_V_BACK,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int DELAY     = 2
) (
  input  logic             PixelClkSrc,
  input  logic             PixelRst,
  input  logic             PixelEn,
  output logic [XBITS-1:0] PixelX,
  output logic [YBITS-1:0] PixelY,
  output logic             FetchActive,
  output logic             HsyncOut,
  output logic             VsyncOut,
  output logic             Blank,
  output logic             LineStart,
  output logic             FrameStart
);

  localparam int HTOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int VTOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1)
  begin : gBadRegion
    $error("vtiming_gen: every region length must be >= 1");
  end

  if (!fits(HTOTAL - 1, XBITS)) begin : gBadXbits
    $error("vtiming_gen: XBITS cannot hold HTOTAL-1");
  end

  if (!fits(VTOTAL - 1, YBITS)) begin : gBadYbits
    $error("vtiming_gen: YBITS cannot hold VTOTAL-1");
  end

  if (DELAY < 0 || DELAY > 7) begin : gBadDelay
    $error("vtiming_gen: DELAY must be 0..7");
  end

  axis_state_t      hRegion;
  axis_state_t      vRegion;
  h_state_t         hState;
  v_state_t         vState;
  logic [XBITS-1:0] hPos;
  logic [YBITS-1:0] vPos;
  logic             hWrap;
  logic             vWrap;
  logic             vAdv;
  logic             atFrameStart;
  sync_bits_t       raw;
  sync_bits_t       outBits;
  sync_bits_t       pipe [0:DELAY];

  assign vAdv = PixelEn & hWrap;

  vtiming_axis #(
    .W       (XBITS),
    .L_ACT   (H_ACTIVE),
    .L_FRONT (H_FRONT),
    .L_SYNC  (H_SYNC),
    .L_BACK  (H_BACK)
  ) uHoriz (
    .clk    (PixelClkSrc),
    .rst    (PixelRst),
    .adv    (PixelEn),
    .region (hRegion),
    .pos    (hPos),
    .wrap   (hWrap)
  );

  vtiming_axis #(
    .W       (YBITS),
    .L_ACT   (V_ACTIVE),
    .L_FRONT (V_FRONT),
    .L_SYNC  (V_SYNC),
    .L_BACK  (V_BACK)
  ) uVert (
    .clk    (PixelClkSrc),
    .rst    (PixelRst),
    .adv    (vAdv),
    .region (vRegion),
    .pos    (vPos),
    .wrap   (vWrap)
  );

  assign hState = h_state_t'(hRegion);
  assign vState = v_state_t'(vRegion);

  // atFrameStart marks that the counters sit at X=0,Y=0: set by
  // reset and by the enabled edge that wraps both axes together.
  always_comb begin
    raw       = SYNC_FLUSHED;
    raw.hsync = (hState == H_SY);
    raw.vsync = (vState == V_SY);
    raw.blank = !((hState == H_ACT) && (vState == V_ACT));
    raw.line  = (hPos == '0);
    raw.frame = atFrameStart;
  end

  always_ff @(posedge PixelClkSrc) begin
    if (PixelRst) begin
      PixelX       <= '0;
      PixelY       <= '0;
      FetchActive  <= 1'b0;
      atFrameStart <= 1'b1;
    end else if (PixelEn) begin
      PixelX       <= hPos;
      PixelY       <= vPos;
      FetchActive  <= !raw.blank;
      atFrameStart <= hWrap & vWrap;
    end
  end

  // pipe[0] is aligned with PixelX; pipe[DELAY] drives the outputs.
  for (genvar g = 0; g <= DELAY; g++) begin : gStage
    if (g == 0) begin : gHead
      always_ff @(posedge PixelClkSrc) begin
        if (PixelRst) begin
          pipe[g] <= SYNC_FLUSHED;
        end else if (PixelEn) begin
          pipe[g] <= raw;
        end
      end
    end else begin : gTail
      always_ff @(posedge PixelClkSrc) begin
        if (PixelRst) begin
          pipe[g] <= SYNC_FLUSHED;
        end else if (PixelEn) begin
          pipe[g] <= pipe[g-1];
        end
      end
    end
  end

  assign outBits    = pipe[DELAY];
  assign HsyncOut   = outBits.hsync ^ ~HSYNC_POL;
  assign VsyncOut   = outBits.vsync ^ ~VSYNC_POL;
  assign Blank      = outBits.blank;
  assign LineStart  = outBits.line;
  assign FrameStart = outBits.frame;

endmodule

// File: tb/tb_vtiming_gen.sv
// Bench for vtiming_gen: five configurations against a
// coordinate-arithmetic reference model under random enable/reset.
module tb_vtiming_gen;

  localparam int ND = 5;
  localparam int HA [ND] = '{640, 8, 8, 8, 1};
  localparam int HF [ND] = '{16, 2, 2, 2, 1};
  localparam int HS [ND] = '{96, 3, 3, 3, 1};
  localparam int HB [ND] = '{48, 2, 2, 2, 1};
  localparam int VA [ND] = '{480, 6, 6, 6, 1};
  localparam int VF [ND] = '{10, 2, 2, 2, 1};
  localparam int VS [ND] = '{2, 2, 2, 2, 1};
  localparam int VB [ND] = '{33, 3, 3, 3, 1};
  localparam bit HP [ND] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam bit VP [ND] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam int DL [ND] = '{2, 2, 5, 0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en = 1'b0;
  int   n = 0;
  int   checks = 0;
  int   errors = 0;

  logic [9:0] xA, yA;
  logic [3:0] xB, yB, xC, yC, xD, yD;
  logic [1:0] xE, yE;
  logic [ND-1:0] fa, hs, vs, bl, ls, fs;

  vtiming_gen uA (
    .PixelClkSrc (clk), .PixelRst (rst), .PixelEn (en),
    .PixelX (xA), .PixelY (yA), .FetchActive (fa[0]),
    .HsyncOut (hs[0]), .VsyncOut (vs[0]), .Blank (bl[0]),
    .LineStart (ls[0]), .FrameStart (fs[0])
  );

  vtiming_gen #(
    .XBITS (4), .YBITS (4),
    .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_ACTIVE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
    .DELAY (2)
  ) uB (
    .PixelClkSrc (clk), .PixelRst (rst), .PixelEn (en),
    .PixelX (xB), .PixelY (yB), .FetchActive (fa[1]),
    .HsyncOut (hs[1]), .VsyncOut (vs[1]), .Blank (bl[1]),
    .LineStart (ls[1]), .FrameStart (fs[1])
  );

  vtiming_gen #(
    .XBITS (4), .YBITS (4),
    .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_ACTIVE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b1), .DELAY (5)
  ) uC (
    .PixelClkSrc (clk), .PixelRst (rst), .PixelEn (en),
    .PixelX (xC), .PixelY (yC), .FetchActive (fa[2]),
    .HsyncOut (hs[2]), .VsyncOut (vs[2]), .Blank (bl[2]),
    .LineStart (ls[2]), .FrameStart (fs[2])
  );

  vtiming_gen #(
    .XBITS (4), .YBITS (4),
    .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_ACTIVE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
    .DELAY (0)
  ) uD (
    .PixelClkSrc (clk), .PixelRst (rst), .PixelEn (en),
    .PixelX (xD), .PixelY (yD), .FetchActive (fa[3]),
    .HsyncOut (hs[3]), .VsyncOut (vs[3]), .Blank (bl[3]),
    .LineStart (ls[3]), .FrameStart (fs[3])
  );

  vtiming_gen #(
    .XBITS (2), .YBITS (2),
    .H_ACTIVE (1), .H_FRONT (1), .H_SYNC (1), .H_BACK (1),
    .V_ACTIVE (1), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .DELAY (1)
  ) uE (
    .PixelClkSrc (clk), .PixelRst (rst), .PixelEn (en),
    .PixelX (xE), .PixelY (yE), .FetchActive (fa[4]),
    .HsyncOut (hs[4]), .VsyncOut (vs[4]), .Blank (bl[4]),
    .LineStart (ls[4]), .FrameStart (fs[4])
  );

  // Expected outputs after cnt enabled edges since reset.
  // Stage 0 shows pixel index cnt-1; outputs show cnt-1-DELAY.
  function automatic logic [25:0] model(input int d, input int cnt);
    int ht, vt, k, x0, y0, xk, yk;
    bit a, h, v, b, l, f;
    ht = HA[d] + HF[d] + HS[d] + HB[d];
    vt = VA[d] + VF[d] + VS[d] + VB[d];
    x0 = 0; y0 = 0; a = 1'b0;
    if (cnt >= 1) begin
      x0 = (cnt - 1) % ht;
      y0 = ((cnt - 1) / ht) % vt;
      a  = (x0 < HA[d]) && (y0 < VA[d]);
    end
    h = 1'b0; v = 1'b0; b = 1'b1; l = 1'b0; f = 1'b0;
    k = cnt - 1 - DL[d];
    if (k >= 0) begin
      xk = k % ht;
      yk = (k / ht) % vt;
      h = (xk >= HA[d] + HF[d]) && (xk < HA[d] + HF[d] + HS[d]);
      v = (yk >= VA[d] + VF[d]) && (yk < VA[d] + VF[d] + VS[d]);
      b = !((xk < HA[d]) && (yk < VA[d]));
      l = (xk == 0);
      f = (xk == 0) && (yk == 0);
    end
    return {10'(x0), 10'(y0), a, h ^ !HP[d], v ^ !VP[d], b, l, f};
  endfunction

  function automatic logic [25:0] observe(input int d);
    logic [9:0] x, y;
    case (d)
      0: begin x = xA; y = yA; end
      1: begin x = 10'(xB); y = 10'(yB); end
      2: begin x = 10'(xC); y = 10'(yC); end
      3: begin x = 10'(xD); y = 10'(yD); end
      default: begin x = 10'(xE); y = 10'(yE); end
    endcase
    return {x, y, fa[d], hs[d], vs[d], bl[d], ls[d], fs[d]};
  endfunction

  task automatic step(input bit e, input bit r);
    en  = e;
    rst = r;
    @(posedge clk);
    if (r) n = 0;
    else if (e) n++;
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      step(1'($urandom % 2), 1'b1);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (observe(d) !== model(d, n)) begin
          errors++;
          $display("FAIL reset dut%0d got %h want %h",
                   d, observe(d), model(d, n));
        end
      end
    end
  endtask

  task automatic test_continuous();
    int lastFs;
    lastFs = -1;
    for (int c = 0; c < 2500; c++) begin
      step(1'b1, 1'b0);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (observe(d) !== model(d, n)) begin
          errors++;
          if (errors < 20)
            $display("FAIL cont dut%0d n=%0d got %h want %h",
                     d, n, observe(d), model(d, n));
        end
      end
      if (fs[1]) begin
        if (lastFs >= 0) begin
          checks++;
          if (n - lastFs !== 195) begin
            errors++;
            $display("FAIL frame_period got %0d want 195",
                     n - lastFs);
          end
        end
        lastFs = n;
      end
    end
  endtask

  task automatic test_enable_toggle();
    bit e, prevLs;
    prevLs = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      e = (c < 400) ? ((c % 2) == 0) : 1'($urandom % 2);
      step(e, 1'b0);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (observe(d) !== model(d, n)) begin
          errors++;
          if (errors < 20)
            $display("FAIL enable dut%0d n=%0d got %h want %h",
                     d, n, observe(d), model(d, n));
        end
      end
      if (e) begin
        checks++;
        if (prevLs && ls[1]) begin
          errors++;
          $display("FAIL strobe_repeat got 1 want 0 n=%0d", n);
        end
        prevLs = ls[1];
      end
    end
  endtask

  task automatic test_mid_reset();
    int len;
    bit r;
    for (int t = 0; t < 3; t++) begin
      len = 50 + int'($urandom % 250);
      for (int c = 0; c < len + 12; c++) begin
        r = (c >= len) && (c < len + 2);
        step(r ? 1'($urandom % 2) : ($urandom % 4 != 0), r);
        for (int d = 0; d < ND; d++) begin
          checks++;
          if (observe(d) !== model(d, n)) begin
            errors++;
            if (errors < 20)
              $display("FAIL midrst dut%0d n=%0d got %h want %h",
                       d, n, observe(d), model(d, n));
          end
        end
      end
    end
  endtask

  task automatic test_min_mode();
    int hCnt, vCnt;
    hCnt = 0; vCnt = 0;
    step(1'b1, 1'b1);
    for (int c = 0; c < 65; c++) begin
      step(1'b1, 1'b0);
      checks++;
      if (observe(4) !== model(4, n)) begin
        errors++;
        $display("FAIL minmode n=%0d got %h want %h",
                 n, observe(4), model(4, n));
      end
      if (n >= 2) begin
        if (!hs[4]) hCnt++;
        if (!vs[4]) vCnt++;
      end
    end
    checks++;
    if (hCnt !== 16) begin
      errors++;
      $display("FAIL min_hsync_count got %0d want 16", hCnt);
    end
    checks++;
    if (vCnt !== 16) begin
      errors++;
      $display("FAIL min_vsync_count got %0d want 16", vCnt);
    end
  endtask

  task automatic test_delay_alignment();
    int nD, nC;
    nD = -1; nC = -1;
    step(1'b1, 1'b1);
    for (int c = 0; c < 40; c++) begin
      step(1'b1, 1'b0);
      if (nD < 0 && !bl[3]) nD = n;
      if (nC < 0 && !bl[2]) nC = n;
    end
    checks++;
    if (nD !== 1) begin
      errors++;
      $display("FAIL delay0_blank_fall got %0d want 1", nD);
    end
    checks++;
    if (nC - nD !== 5 || nC < 0) begin
      errors++;
      $display("FAIL delay5_blank_lag got %0d want 5", nC - nD);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_enable_toggle();
    test_mid_reset();
    test_min_mode();
    test_delay_alignment();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
